// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and pointer width.
// Latency: none, pure functions.
// Backpressure: not applicable.
package fifo_pkg;

  // Pointers carry one wrap bit above the address so full and empty differ.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  // Width-agnostic: callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Gray-to-binary converter, XOR-prefix from the MSB down; shared with the write side.
// Latency: combinational.
// Backpressure: not applicable.
module gray2bin_conv #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Ripple the running XOR from the top bit toward bit 0.
  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: Gray/binary read pointer, empty, level, almost-empty, underflow.
// Latency: rd_ack same cycle; pointers and flags update one r_clk edge after a pop.
// Backpressure: reads are refused (rd_ack=0) while empty; optional sticky underflow via FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          r_clk,
  input  logic          rst_n,
  input  logic          rd_rq,
  input  logic [AW:0]   rsync_ptr2,
  input  logic [AW:0]   ae_thresh,
  input  logic          underflow_clr,
  output logic [AW-1:0] raddr,
  output logic [AW:0]   rptr,
  output logic          rd_ack,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   rd_level,
  output logic          underflow
);

  localparam int PW = ptr_w(AW);

  logic [PW-1:0] bin;
  logic [PW-1:0] binnext;
  logic [PW-1:0] graynext;
  logic [PW-1:0] wbin;
  logic [PW-1:0] lvl_next;

  gray2bin_conv #(.W(PW)) u_wptr_conv (
    .gray (rsync_ptr2),
    .bin  (wbin)
  );

  assign rd_ack   = rd_rq & ~empty;
  assign binnext  = bin + PW'(rd_ack);
  assign graynext = PW'(bin2gray(32'(binnext)));
  // Level is measured against the delayed write pointer, so it can only under-report.
  assign lvl_next = wbin - binnext;
  assign raddr    = bin[AW-1:0];

  // Pointer, empty, level and almost-empty registers; all track the post-pop pointer.
  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      bin          <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      bin          <= binnext;
      rptr         <= graynext;
      empty        <= (graynext == rsync_ptr2);
      rd_level     <= lvl_next;
      almost_empty <= (lvl_next <= ae_thresh);
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_q;

  // Sticky underflow: a refused request sets it, clear only wins when no new set.
  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (rd_rq & empty) begin
      underflow_q <= 1'b1;
    end else if (underflow_clr) begin
      underflow_q <= 1'b0;
    end
  end

  assign underflow = underflow_q;
`else
  logic unused_underflow_clr;

  assign unused_underflow_clr = underflow_clr;
  assign underflow            = 1'b0;
`endif

endmodule
